// File: rtl/tuner_pkg.sv
// Shared constants for the tuner datapath: word sizes, mixer pipeline
// latencies, scheduler state encoding and the dither LFSR definition.
package tuner_pkg;

    localparam int DSZ         = 16;
    localparam int PSZ         = 11;
    localparam int ASZ         = 32;
    localparam int MIX_PHS_LAT = 6;
    localparam int MIX_DAT_LAT = 2;

    typedef logic [0:0] state_t;
    localparam state_t IDLE    = 1'b0;
    localparam state_t ISSUE_Q = 1'b1;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting left
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with an occupancy count, used to hold completed
// I/Q pairs; the count feeds the scheduler's credit check.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop & ~empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/tuner_mix_sched.sv
// Time-shares one tuner_mixer between I and Q, owns the NCO accumulator and
// buffers I/Q pairs. Define TUNER_MIX_SCHED_DITHER_EN for LFSR phase dither.
module tuner_mix_sched
    import tuner_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [ASZ-1:0] freq_word,
    input  logic           freq_load,
    input  logic [ASZ-1:0] phase_offset,
    input  logic           phase_clr,
    input  logic [DSZ-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           mix_cos,
    output logic [PSZ-1:0] mix_phs,
    output logic [DSZ-1:0] mix_in,
    input  logic [DSZ-1:0] mix_out,
    output logic [DSZ-1:0] out_i,
    output logic [DSZ-1:0] out_q,
    output logic           out_valid,
    input  logic           out_ready
);
    localparam int TAGS     = MIX_PHS_LAT + 1;
    localparam int LOAD_STG = MIX_PHS_LAT - MIX_DAT_LAT - 2;
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int SW       = CW + 1;

    state_t           state;
    logic [ASZ-1:0]   acc;
    logic [ASZ-1:0]   freq_active;
    logic [ASZ-1:0]   freq_pend;
    logic             freq_pend_flag;
    logic             clr_pend_flag;
    logic [PSZ-1:0]   phase_now;
    logic [PSZ-1:0]   phs_hold;
    logic [TAGS-1:0]  tag;
    logic [DSZ-1:0]   dly [LOAD_STG+1];
    logic [DSZ-1:0]   i_hold;
    logic [SW-1:0]    in_flight;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic [2*DSZ-1:0] fifo_head;
    logic             has_credit;
    logic             accept;
    logic             boundary;
    logic             apply_pend;

`ifdef TUNER_MIX_SCHED_DITHER_EN
    logic [15:0]    lfsr;
    logic [ASZ-1:0] dither;

    assign dither = ASZ'(lfsr) & ((ASZ'(1) << (ASZ - PSZ)) - ASZ'(1));

    always_ff @(posedge clk) begin
        if (reset)       lfsr <= LFSR_SEED;
        else if (accept) lfsr <= lfsr_next(lfsr);
    end

    assign phase_now = PSZ'((acc + phase_offset + dither) >> (ASZ - PSZ));
`else
    assign phase_now = PSZ'((acc + phase_offset) >> (ASZ - PSZ));
`endif

    // Each issued pair holds exactly one tag bit until its FIFO write.
    always_comb begin
        in_flight = '0;
        for (int k = 0; k < TAGS; k++) in_flight = in_flight + SW'(tag[k]);
    end

    assign has_credit = (SW'(fifo_count) + in_flight) < SW'(FIFO_DEPTH);
    assign in_ready   = ~reset & enable & (state == IDLE) & has_credit;
    assign accept     = in_valid & in_ready;
    assign boundary   = (state == ISSUE_Q);
    assign apply_pend = boundary | ((state == IDLE) & ~accept);

    assign mix_cos = accept;
    assign mix_phs = accept ? phase_now : ((boundary & ~reset) ? phs_hold : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            acc            <= '0;
            freq_active    <= '0;
            freq_pend      <= '0;
            freq_pend_flag <= 1'b0;
            clr_pend_flag  <= 1'b0;
            phs_hold       <= '0;
        end else begin
            if (accept) begin
                state    <= ISSUE_Q;
                phs_hold <= phase_now;
            end else if (boundary) begin
                state <= IDLE;
            end

            if (apply_pend && clr_pend_flag) acc <= '0;
            else if (boundary)               acc <= acc + freq_active;

            if (apply_pend && freq_pend_flag) freq_active <= freq_pend;

            // A load coincident with an apply stays pending for the next one.
            if (freq_load) begin
                freq_pend      <= freq_word;
                freq_pend_flag <= 1'b1;
            end else if (apply_pend) begin
                freq_pend_flag <= 1'b0;
            end

            if (phase_clr)       clr_pend_flag <= 1'b1;
            else if (apply_pend) clr_pend_flag <= 1'b0;
        end
    end

    // The sample rides a delay line so back-to-back accepts cannot clobber it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag    <= '0;
            mix_in <= '0;
            i_hold <= '0;
            for (int k = 0; k <= LOAD_STG; k++) dly[k] <= '0;
        end else begin
            tag    <= {tag[TAGS-2:0], accept};
            dly[0] <= in_data;
            for (int k = 1; k <= LOAD_STG; k++) dly[k] <= dly[k-1];
            if (tag[LOAD_STG]) mix_in <= dly[LOAD_STG];
            if (tag[TAGS-2])   i_hold <= mix_out;
        end
    end

    sync_fifo #(
        .WIDTH (2*DSZ),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tag[TAGS-1]),
        .push_data ({i_hold, mix_out}),
        .pop       (out_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_i     = fifo_head[2*DSZ-1:DSZ];
    assign out_q     = fifo_head[DSZ-1:0];
    assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_tuner_mix_sched.sv
// Directed bench for tuner_mix_sched with a behavioural tuner_mixer model
// (phase latency 6, data latency 2) closing the loop around the scheduler.
module tb_tuner_mix_sched;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] freq_word;
    logic        freq_load;
    logic [31:0] phase_offset;
    logic        phase_clr;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mix_cos;
    logic [10:0] mix_phs;
    logic [15:0] mix_in;
    logic [15:0] mix_out = '0;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    int          phs_q[$];
    logic [31:0] pair_q[$];

    logic [4:0]  cos_sr = '0;
    logic [10:0] phs_sr [5] = '{default: '0};
    logic [15:0] in_d = '0;

    tuner_mix_sched dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .freq_word    (freq_word),
        .freq_load    (freq_load),
        .phase_offset (phase_offset),
        .phase_clr    (phase_clr),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mix_cos      (mix_cos),
        .mix_phs      (mix_phs),
        .mix_in       (mix_in),
        .mix_out      (mix_out),
        .out_i        (out_i),
        .out_q        (out_q),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mix_fn(input logic c, input logic [10:0] p, input logic [15:0] d);
        real    ang;
        real    v;
        int     coef;
        longint prod;
        ang  = 2.0 * 3.14159265358979 * real'(p) / 2048.0;
        v    = c ? $cos(ang) : $sin(ang);
        coef = $rtoi(32767.0 * v);
        prod = longint'($signed(d)) * longint'(coef);
        return 16'(prod >>> 15);
    endfunction

    // Mixer model: out in cycle k uses phs/cos from k-6 and in from k-2.
    always @(posedge clk) begin
        cos_sr    <= {cos_sr[3:0], mix_cos};
        phs_sr[0] <= mix_phs;
        for (int i = 1; i < 5; i++) phs_sr[i] <= phs_sr[i-1];
        in_d      <= mix_in;
        mix_out   <= mix_fn(cos_sr[4], phs_sr[4], in_d);
    end

    always @(posedge clk) begin
        if (mix_cos) phs_q.push_back(int'(mix_phs));
        if (out_valid && out_ready) pair_q.push_back({out_i, out_q});
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic one_accept(input logic [15:0] d);
        int guard;
        guard = 0;
        @(negedge clk); in_valid = 1'b1; in_data = d; #1;
        while (!in_ready && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL accept_timeout got in_ready=%0b want 1", in_ready);
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; in_valid = 1'b1; in_data = 16'h7777;
        out_ready = 1'b1; freq_load = 1'b0; phase_clr = 1'b0;
        freq_word = '0; phase_offset = '0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b want=0", in_ready); end
        total++; if (mix_cos !== 1'b0) begin bad++; $display("[TB] FAIL reset_mix_cos got=%0b want=0", mix_cos); end
        total++; if (mix_phs !== 11'd0) begin bad++; $display("[TB] FAIL reset_mix_phs got=%0d want=0", mix_phs); end
        total++; if (mix_in !== 16'd0) begin bad++; $display("[TB] FAIL reset_mix_in got=%0d want=0", mix_in); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if ({out_i, out_q} !== 32'd0) begin bad++; $display("[TB] FAIL reset_out_data got=%h want=0", {out_i, out_q}); end
        @(negedge clk); reset = 1'b0; in_valid = 1'b0; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_in_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_latency();
        pair_q.delete();
        @(negedge clk); in_valid = 1'b1; in_data = 16'd1234; #1;
        total++; if (mix_cos !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL lat_issue_i got cos=%0b rdy=%0b want 1 1", mix_cos, in_ready); end
        total++; if (mix_phs !== 11'd0) begin bad++; $display("[TB] FAIL lat_phs_i got=%0d want=0", mix_phs); end
        @(negedge clk); in_valid = 1'b0; in_data = 16'd0; #1;
        total++; if (mix_cos !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL lat_issue_q got cos=%0b rdy=%0b want 0 0", mix_cos, in_ready); end
        repeat (2) @(negedge clk);
        #1;
        total++; if (mix_in !== 16'd0) begin bad++; $display("[TB] FAIL lat_min_t3 got=%0d want=0", mix_in); end
        @(negedge clk); #1;
        total++; if (mix_in !== 16'd1234) begin bad++; $display("[TB] FAIL lat_min_t4 got=%0d want=1234", mix_in); end
        @(negedge clk); #1;
        total++; if (mix_in !== 16'd1234) begin bad++; $display("[TB] FAIL lat_min_t5 got=%0d want=1234", mix_in); end
        repeat (2) @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL lat_valid_t7 got=%0b want=0", out_valid); end
        @(negedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL lat_valid_t8 got=%0b want=1", out_valid); end
        total++; if (out_i !== 16'd1233 || out_q !== 16'd0) begin bad++; $display("[TB] FAIL lat_pair got=(%0d,%0d) want=(1233,0)", $signed(out_i), $signed(out_q)); end
        @(negedge clk); enable = 1'b0; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL enable_low_in_ready got=%0b want=0", in_ready); end
        enable = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int accepts;
        logic [15:0] exp_i [4];
        exp_i = '{16'd99, 16'd199, 16'd299, 16'd399};
        accepts = 0;
        @(negedge clk); out_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 16'(100 * (accepts + 1)); #1;
            if (in_valid && in_ready) accepts++;
        end
        @(negedge clk); in_valid = 1'b0; #1;
        total++; if (accepts != 4) begin bad++; $display("[TB] FAIL bp_accepts got=%0d want=4", accepts); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready got=%0b want=0", in_ready); end
        total++; if (out_valid !== 1'b1 || out_i !== 16'd99 || out_q !== 16'd0) begin bad++; $display("[TB] FAIL bp_head got v=%0b (%0d,%0d) want 1 (99,0)", out_valid, out_i, out_q); end
        pair_q.delete();
        @(negedge clk); out_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        total++; if (pair_q.size() != 4) begin bad++; $display("[TB] FAIL bp_drain_count got=%0d want=4", pair_q.size()); end
        if (pair_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (pair_q[k] !== {exp_i[k], 16'd0}) begin bad++; $display("[TB] FAIL bp_pair%0d got=%h want=%h", k, pair_q[k], {exp_i[k], 16'd0}); end
            end
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty got=%0b want=0", out_valid); end
    endtask

    task automatic test_rotation();
        int n;
        int guard;
        int di;
        int dq;
        int exp_phs [5];
        int exp_i [5];
        int exp_q [5];
        exp_phs = '{0, 512, 1024, 1536, 0};
        exp_i   = '{16383, 0, -16383, 0, 16383};
        exp_q   = '{0, 16383, 0, -16383, 0};
        @(negedge clk); freq_word = 32'h40000000; freq_load = 1'b1;
        @(negedge clk); freq_load = 1'b0;
        @(negedge clk);
        phs_q.delete(); pair_q.delete();
        n = 0; guard = 0;
        while (n < 5 && guard < 60) begin
            @(negedge clk); in_valid = 1'b1; in_data = 16'd16384; #1;
            if (in_ready) n++;
            guard++;
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (14) @(negedge clk);
        total++; if (phs_q.size() != 5) begin bad++; $display("[TB] FAIL rot_issue_count got=%0d want=5", phs_q.size()); end
        if (phs_q.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (phs_q[k] != exp_phs[k]) begin bad++; $display("[TB] FAIL rot_phs%0d got=%0d want=%0d", k, phs_q[k], exp_phs[k]); end
            end
        end
        total++; if (pair_q.size() != 5) begin bad++; $display("[TB] FAIL rot_pair_count got=%0d want=5", pair_q.size()); end
        if (pair_q.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                di = int'($signed(pair_q[k][31:16])) - exp_i[k];
                dq = int'($signed(pair_q[k][15:0])) - exp_q[k];
                total++;
                if (di > 2 || di < -2 || dq > 2 || dq < -2) begin
                    bad++;
                    $display("[TB] FAIL rot_pair%0d got=(%0d,%0d) want=(%0d,%0d)+-2", k,
                             $signed(pair_q[k][31:16]), $signed(pair_q[k][15:0]), exp_i[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_retune();
        int exp_phs [3];
        exp_phs = '{512, 1024, 1280};
        phs_q.delete();
        one_accept(16'd500);
        freq_word = 32'h20000000; freq_load = 1'b1;
        @(negedge clk); freq_load = 1'b0;
        one_accept(16'd500);
        one_accept(16'd500);
        repeat (10) @(negedge clk);
        total++; if (phs_q.size() != 3) begin bad++; $display("[TB] FAIL retune_count got=%0d want=3", phs_q.size()); end
        if (phs_q.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (phs_q[k] != exp_phs[k]) begin bad++; $display("[TB] FAIL retune_phs%0d got=%0d want=%0d", k, phs_q[k], exp_phs[k]); end
            end
        end
    endtask

    task automatic test_wrap();
        int exp_phs [4];
        exp_phs = '{0, 2047, 1, 0};
        @(negedge clk); phase_clr = 1'b1; freq_word = 32'hFFFFFFFF; freq_load = 1'b1;
        @(negedge clk); phase_clr = 1'b0; freq_load = 1'b0;
        @(negedge clk);
        phs_q.delete();
        one_accept(16'd700);
        one_accept(16'd700);
        @(negedge clk); phase_clr = 1'b1;
        @(negedge clk); phase_clr = 1'b0; phase_offset = 32'h00200000;
        @(negedge clk);
        one_accept(16'd700);
        one_accept(16'd700);
        @(negedge clk); phase_offset = 32'h0;
        repeat (10) @(negedge clk);
        total++; if (phs_q.size() != 4) begin bad++; $display("[TB] FAIL wrap_count got=%0d want=4", phs_q.size()); end
        if (phs_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (phs_q[k] != exp_phs[k]) begin bad++; $display("[TB] FAIL wrap_phs%0d got=%0d want=%0d", k, phs_q[k], exp_phs[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        pair_q.delete();
        one_accept(16'd3000);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_out_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_in_ready got=%0b want=1", in_ready); end
        repeat (12) @(negedge clk);
        #1;
        total++; if (pair_q.size() != 0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_no_pair got=%0d pairs want=0", pair_q.size()); end
        @(negedge clk); in_valid = 1'b1; in_data = 16'd3000; #1;
        total++; if (mix_cos !== 1'b1 || mix_phs !== 11'd0) begin bad++; $display("[TB] FAIL rmid_first_phs got cos=%0b phs=%0d want 1 0", mix_cos, mix_phs); end
        @(negedge clk); in_valid = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_rotation();
        test_retune();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
